// File: rtl/pps_loop_filter_dac.sv
`default_nettype none
// ============================================================================
// Module   : pps_loop_filter_dac
// Purpose  : PI loop filter for the disciplined oscillator. Each phase-error
//            strobe updates a saturating integrator, forms a clamped 16-bit
//            DAC code and streams it to the SPI master as two bytes, MSB
//            first, over the ready/valid handshake.
// Options  : DAC_LOOP_MANUAL_EN - compiles in the manual DAC override with a
//            bumpless integrator preload on return to closed loop.
// Revision : 1.0 - initial release
// ============================================================================
module pps_loop_filter_dac #(
  parameter int          KP_SHIFT = 4,
  parameter int          KI_SHIFT = 8,
  parameter logic [15:0] DAC_MID  = 16'h8000,
  parameter int          ACC_W    = 32
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Err_DV,
  input  logic [15:0] i_Phase_Err,
  input  logic        i_Manual,
  input  logic [15:0] i_Manual_Val,
  input  logic        i_TX_Ready,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  output logic [15:0] o_DAC_Val,
  output logic        o_Busy,
  output logic        o_Sat,
  output logic        o_Drop
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC1   = 3'd1,
    S_CALC2   = 3'd2,
    S_SEND_HI = 3'd3,
    S_WAIT_HI = 3'd4,
    S_SEND_LO = 3'd5,
    S_WAIT_LO = 3'd6
  } state_t;

  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                   r_state;
  logic signed [15:0]       r_err;
  logic signed [ACC_W-1:0]  r_integ;
  logic signed [ACC_W-1:0]  r_cand;
  logic [15:0]              r_dac;
  logic                     r_sat;
  logic                     r_drop;
  logic                     r_tx_dv;
  logic [7:0]               r_tx_byte;
`ifdef DAC_LOOP_MANUAL_EN
  logic                     r_manual;
`endif

  // Integrator candidate: integ + err computed one bit wider, then saturated.
  logic signed [ACC_W:0]    w_err_acc1;
  logic signed [ACC_W:0]    w_integ_acc1;
  logic signed [ACC_W:0]    w_cand_raw;
  logic signed [ACC_W-1:0]  w_cand;

  assign w_err_acc1   = {{(ACC_W+1-16){r_err[15]}}, r_err};
  assign w_integ_acc1 = {r_integ[ACC_W-1], r_integ};
  assign w_cand_raw   = w_integ_acc1 + w_err_acc1;

  // Saturate the candidate when the top two bits of the wide sum disagree.
  always_comb begin
    w_cand = w_cand_raw[ACC_W-1:0];
    if (w_cand_raw[ACC_W] != w_cand_raw[ACC_W-1]) begin
      w_cand = w_cand_raw[ACC_W] ? c_acc_min : c_acc_max;
    end
  end

  // Output sum: two guard bits so neither term can wrap before the clamp.
  logic signed [ACC_W+1:0]  w_mid_x;
  logic signed [ACC_W+1:0]  w_err_x;
  logic signed [ACC_W+1:0]  w_cand_x;
  logic signed [ACC_W+1:0]  w_sum;
  logic [15:0]              w_clamp_val;
  logic                     w_clamped;

  assign w_mid_x  = {{(ACC_W+2-16){1'b0}}, DAC_MID};
  assign w_err_x  = {{(ACC_W+2-16){r_err[15]}}, r_err};
  assign w_cand_x = {{2{r_cand[ACC_W-1]}}, r_cand};
  assign w_sum    = w_mid_x + (w_err_x >>> KP_SHIFT) + (w_cand_x >>> KI_SHIFT);

  // Clamp the sum into the 16-bit unsigned DAC range.
  always_comb begin
    w_clamp_val = w_sum[15:0];
    w_clamped   = 1'b0;
    if (w_sum[ACC_W+1]) begin
      w_clamp_val = 16'h0000;
      w_clamped   = 1'b1;
    end else if (|w_sum[ACC_W:16]) begin
      w_clamp_val = 16'hFFFF;
      w_clamped   = 1'b1;
    end
  end

  // Commit values; integrator only advances when the output was not clamped.
  logic [15:0]              w_next_dac;
  logic                     w_next_sat;
  logic signed [ACC_W-1:0]  w_next_integ;

`ifdef DAC_LOOP_MANUAL_EN
  logic signed [16:0]       w_man_diff;
  logic signed [ACC_W-1:0]  w_man_integ;

  assign w_man_diff  = $signed({1'b0, i_Manual_Val}) - $signed({1'b0, DAC_MID});
  assign w_man_integ = {{(ACC_W-17){w_man_diff[16]}}, w_man_diff} <<< KI_SHIFT;
`else
  logic w_unused_manual;
  assign w_unused_manual = ^{i_Manual, i_Manual_Val};
`endif

  // Select between closed-loop result and manual override.
  always_comb begin
    w_next_dac   = w_clamp_val;
    w_next_sat   = w_clamped;
    w_next_integ = w_clamped ? r_integ : r_cand;
`ifdef DAC_LOOP_MANUAL_EN
    if (r_manual) begin
      w_next_dac   = i_Manual_Val;
      w_next_sat   = 1'b0;
      w_next_integ = w_man_integ;
    end
`endif
  end

  // Sequencer: accept strobe, two calc cycles, then two handshaked bytes.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state   <= S_IDLE;
      r_err     <= '0;
      r_integ   <= '0;
      r_cand    <= '0;
      r_dac     <= DAC_MID;
      r_sat     <= 1'b0;
      r_drop    <= 1'b0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
`ifdef DAC_LOOP_MANUAL_EN
      r_manual  <= 1'b0;
`endif
    end else begin
      r_tx_dv <= 1'b0;
      r_drop  <= i_Err_DV && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_Err_DV) begin
            r_err   <= $signed(i_Phase_Err);
`ifdef DAC_LOOP_MANUAL_EN
            r_manual <= i_Manual;
`endif
            r_state <= S_CALC1;
          end
        end
        S_CALC1: begin
          r_cand  <= w_cand;
          r_state <= S_CALC2;
        end
        S_CALC2: begin
          r_dac   <= w_next_dac;
          r_sat   <= w_next_sat;
          r_integ <= w_next_integ;
          r_state <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (i_TX_Ready) begin
            r_tx_byte <= r_dac[15:8];
            r_tx_dv   <= 1'b1;
            r_state   <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          // The pulse cycle is the first WAIT cycle; ready is stale there.
          if (!r_tx_dv && i_TX_Ready) r_state <= S_SEND_LO;
        end
        S_SEND_LO: begin
          if (i_TX_Ready) begin
            r_tx_byte <= r_dac[7:0];
            r_tx_dv   <= 1'b1;
            r_state   <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!r_tx_dv && i_TX_Ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_TX_DV   = r_tx_dv;
  assign o_TX_Byte = r_tx_byte;
  assign o_DAC_Val = r_dac;
  assign o_Busy    = (r_state != S_IDLE);
  assign o_Sat     = r_sat;
  assign o_Drop    = r_drop;

endmodule
`default_nettype wire
